// File: rtl/scr1_ahb_pkg.sv
// Shared AHB-Lite definitions for the stall-injecting test memory.
// Includes transfer/size encodings, slave FSM states and the byte-lane helper.
package scr1_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } scr1_htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } scr1_hsize_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ERR1 = 2'd2,
        ERR2 = 2'd3
    } scr1_ahb_state_e;

    // Byte lanes touched by a transfer; unsupported sizes select no lanes.
    function automatic logic [3:0] ahb_lane_mask(input logic [2:0] hsize,
                                                 input logic [1:0] addr);
        logic [3:0] mask;
        case (hsize)
            HSIZE_BYTE: mask = 4'b0001 << addr;
            HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/scr1_tb_sram.sv
// Word array with byte-enable write and a registered, write-first read.
// A read of the word being written in the same cycle returns the merged data.
module scr1_tb_sram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [2**AW];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic [31:0] merged;

    always_comb begin
        merged = mem_q[raddr_i];
        for (int i = 0; i < 4; i++) begin
            if (we_i && be_i[i] && (waddr_i == raddr_i)) begin
                merged[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
        rdata_d = re_i ? merged : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Array contents are deliberately left unreset; only the read register clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scr1_ahb_stall_mem.sv
// AHB-Lite single-transfer slave memory that inserts wait states from a rotating
// stall pattern and answers illegal transfers with a two-cycle ERROR response.
module scr1_ahb_stall_mem
    import scr1_ahb_pkg::*;
#(
    parameter int MEM_POWER_SIZE = 16,
    parameter int STALL_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_pattern,
    input  logic [1:0]         htrans,
    input  logic [31:0]        haddr,
    input  logic [2:0]         hsize,
    input  logic               hwrite,
    input  logic [31:0]        hwdata,
    output logic               hready,
    output logic [31:0]        hrdata,
    output logic               hresp
);

    localparam int AW = MEM_POWER_SIZE - 2;

    scr1_ahb_state_e            state_q, state_d;
    logic [STALL_W-1:0]         pat_q, pat_d;
    logic [MEM_POWER_SIZE-1:0]  addr_q, addr_d;
    logic [2:0]                 size_q, size_d;
    logic                       wr_q, wr_d;

    logic in_range;
    logic misaligned;
    logic legal;
    logic accept;
    logic complete;
    logic sram_we;
    logic sram_re;
    logic unused_htrans;

    // htrans[0] only separates IDLE/BUSY and NONSEQ/SEQ, which are treated alike.
    assign unused_htrans = htrans[0];

    assign in_range   = (haddr >> MEM_POWER_SIZE) == 32'd0;
    assign misaligned = ((hsize == HSIZE_HALF) && haddr[0]) ||
                        ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
    assign legal      = in_range && (hsize <= HSIZE_WORD) && !misaligned;
    assign accept     = hready && htrans[1];

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        addr_d   = addr_q;
        size_d   = size_q;
        wr_d     = wr_q;
        hready   = 1'b1;
        hresp    = 1'b0;
        complete = 1'b0;

        case (state_q)
            DATA: begin
                hready   = pat_q[0];
                complete = pat_q[0];
                pat_d    = {pat_q[0], pat_q[STALL_W-1:1]};
            end
            ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = ERR2;
            end
            ERR2: begin
                hresp = 1'b1;
            end
            default: ;
        endcase

        // Any cycle that ends with hready=1 may take the next address phase.
        if (hready) begin
            if (htrans[1]) begin
                state_d = legal ? DATA : ERR1;
                addr_d  = haddr[MEM_POWER_SIZE-1:0];
                size_d  = hsize;
                wr_d    = hwrite;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= (stall_pattern == '0) ? '1 : stall_pattern;
            addr_q  <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
        end
    end

    assign sram_we = complete && wr_q && !rst;
    assign sram_re = accept && legal && !hwrite && !rst;

    scr1_tb_sram #(
        .AW (AW)
    ) u_sram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (sram_we),
        .be_i    (ahb_lane_mask(size_q, addr_q[1:0])),
        .waddr_i (addr_q[MEM_POWER_SIZE-1:2]),
        .wdata_i (hwdata),
        .re_i    (sram_re),
        .raddr_i (haddr[MEM_POWER_SIZE-1:2]),
        .rdata_o (hrdata)
    );

endmodule

// File: tb/tb_scr1_ahb_stall_mem.sv
// Bench for scr1_ahb_stall_mem: a pipelined AHB master driving directed and random
// transfers, checked against a byte-level memory and stall-pattern model.
module tb_scr1_ahb_stall_mem;

    localparam logic [31:0] MEM_BYTES = 32'h0001_0000;
    localparam int          RUN_LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] stall_pattern;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;

    always #5 clk = ~clk;

    scr1_ahb_stall_mem #(
        .MEM_POWER_SIZE (16),
        .STALL_W        (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_pattern (stall_pattern),
        .htrans        (htrans),
        .haddr         (haddr),
        .hsize         (hsize),
        .hwrite        (hwrite),
        .hwdata        (hwdata),
        .hready        (hready),
        .hrdata        (hrdata),
        .hresp         (hresp)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          gap;
    } xfer_t;

    xfer_t       xq[$];
    logic [31:0] mem_m [int];
    logic [31:0] pat_m;
    int          pidx;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_illegal(input xfer_t x);
        return (x.addr >= MEM_BYTES) || (x.size > 3'd2) ||
               (x.size == 3'd1 && (x.addr % 2) != 0) ||
               (x.size == 3'd2 && (x.addr % 4) != 0);
    endfunction

    task automatic model_write(input xfer_t x);
        int          w;
        int          nb;
        int          off;
        logic [31:0] v;
        w   = int'(x.addr >> 2);
        nb  = 1 << x.size;
        off = int'(x.addr % 4);
        v   = mem_m.exists(w) ? mem_m[w] : 32'h0;
        for (int b = off; b < off + nb; b++) v[8*b +: 8] = x.wdata[8*b +: 8];
        mem_m[w] = v;
    endtask

    task automatic push(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input int gap);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata; x.gap = gap;
        xq.push_back(x);
    endtask

    task automatic do_reset(input logic [31:0] p);
        rst = 1'b1;
        stall_pattern = p;
        htrans = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pat_m = (p == 32'h0) ? 32'hFFFF_FFFF : p;
        pidx = 0;
        chk("rst_hready", {31'b0, hready}, 32'd1);
        chk("rst_hresp", {31'b0, hresp}, 32'd0);
        chk("rst_hrdata", hrdata, 32'h0);
    endtask

    // Issues every queued transfer back to back and checks each bus cycle.
    task automatic run_queue();
        xfer_t dp;
        bit    dp_valid;
        bit    dp_err;
        bit    err_second;
        bit    present;
        bit    exp_rdy;
        bit    exp_resp;
        int    guard;
        dp_valid = 0; dp_err = 0; err_second = 0; guard = 0;
        while ((xq.size() > 0 || dp_valid) && guard < RUN_LIMIT) begin
            guard++;
            present = 0;
            if (xq.size() > 0) begin
                if (xq[0].gap > 0) xq[0].gap = xq[0].gap - 1;
                else present = 1;
            end
            if (present) begin
                htrans = 2'($urandom_range(2, 3));
                haddr  = xq[0].addr;
                hsize  = xq[0].size;
                hwrite = xq[0].wr;
            end else begin
                htrans = 2'($urandom_range(0, 1));
                haddr  = $urandom;
                hsize  = 3'($urandom_range(0, 7));
                hwrite = 1'($urandom_range(0, 1));
            end
            hwdata = (dp_valid && dp.wr) ? dp.wdata : $urandom;

            exp_rdy = 1; exp_resp = 0;
            if (dp_valid && dp_err) begin
                exp_resp = 1;
                exp_rdy  = err_second;
            end else if (dp_valid) begin
                exp_rdy = pat_m[pidx % 32];
                pidx++;
            end

            @(negedge clk);
            chk("hready", {31'b0, hready}, {31'b0, exp_rdy});
            chk("hresp", {31'b0, hresp}, {31'b0, exp_resp});
            if (dp_valid && !dp_err && exp_rdy) begin
                if (dp.wr) model_write(dp);
                else if (mem_m.exists(int'(dp.addr >> 2)))
                    chk("hrdata", hrdata, mem_m[int'(dp.addr >> 2)]);
            end
            if (dp_valid && dp_err) err_second = 1;
            if (exp_rdy) begin
                dp_valid = 0;
                if (present) begin
                    dp = xq.pop_front();
                    dp_valid = 1;
                    dp_err = is_illegal(dp);
                    err_second = 0;
                end
            end
            @(posedge clk);
            #1;
        end
        if (guard >= RUN_LIMIT) begin
            total++;
            bad++;
            $error("FAIL run_timeout observed=%0d cycles expected=queue drained", guard);
            xq.delete();
        end
        htrans = 2'b00;
    endtask

    task automatic random_phase(input logic [31:0] p, input int n);
        logic [2:0]  sz;
        logic [31:0] a;
        int          kind;
        do_reset(p);
        for (int w = 0; w < 16; w++) push(1'b1, 32'h200 + 32'(4 * w), 3'd2, $urandom, 0);
        run_queue();
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 9);
            sz   = 3'($urandom_range(0, 2));
            a    = 32'h200 + 32'($urandom_range(0, 63));
            if (sz == 3'd1) a[0] = 1'b0;
            if (sz == 3'd2) a[1:0] = 2'b00;
            if (kind == 0) a = MEM_BYTES + 32'($urandom_range(0, 1000)) * 4;
            if (kind == 1) sz = 3'($urandom_range(3, 7));
            if (kind == 2 && sz != 3'd0) a[0] = 1'b1;
            push(1'($urandom_range(0, 1)), a, sz, $urandom,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
        run_queue();
    endtask

    initial begin
        stall_pattern = 32'h0; htrans = 2'b00; haddr = 32'h0;
        hsize = 3'd0; hwrite = 1'b0; hwdata = 32'h0;

        // Zero-wait write then read of the same word.
        do_reset(32'hFFFF_FFFF);
        push(1'b1, 32'h100, 3'd2, 32'hDEAD_BEEF, 0);
        push(1'b0, 32'h100, 3'd2, 32'h0, 0);
        run_queue();

        // Pattern 0b101: first read immediate, second waits one cycle.
        do_reset(32'h0000_0005);
        push(1'b0, 32'h100, 3'd2, 32'h0, 0);
        push(1'b0, 32'h100, 3'd2, 32'h0, 0);
        run_queue();

        // Byte merge into an existing word.
        do_reset(32'hFFFF_FFFF);
        push(1'b1, 32'h100, 3'd2, 32'h1122_3344, 0);
        push(1'b1, 32'h103, 3'd0, {8'hAA, 24'($urandom)}, 0);
        push(1'b0, 32'h100, 3'd2, 32'h0, 0);
        run_queue();

        // Misaligned, out-of-range and erroring write, then readback.
        push(1'b0, 32'h102, 3'd2, 32'h0, 0);
        push(1'b0, MEM_BYTES, 3'd2, 32'h0, 0);
        push(1'b1, 32'h101, 3'd2, 32'hFFFF_FFFF, 0);
        push(1'b1, 32'h100, 3'd5, 32'hFFFF_FFFF, 0);
        push(1'b0, 32'h100, 3'd2, 32'h0, 0);
        run_queue();

        // Read immediately after write to the same word.
        push(1'b1, 32'h40, 3'd2, 32'h1234_5678, 0);
        push(1'b0, 32'h40, 3'd2, 32'h0, 0);
        run_queue();

        // Reset during a stalled write abandons it.
        do_reset(32'h0000_0002);
        htrans = 2'b10; haddr = 32'h100; hsize = 3'd2; hwrite = 1'b1;
        @(negedge clk);
        chk("mid_rst_accept", {31'b0, hready}, 32'd1);
        @(posedge clk);
        #1;
        htrans = 2'b00; hwdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("mid_rst_stall", {31'b0, hready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pat_m = 32'h0000_0002;
        pidx = 0;
        chk("mid_rst_hready", {31'b0, hready}, 32'd1);
        chk("mid_rst_hresp", {31'b0, hresp}, 32'd0);
        chk("mid_rst_hrdata", hrdata, 32'h0);
        push(1'b0, 32'h100, 3'd2, 32'h0, 0);
        run_queue();

        random_phase($urandom, 80);
        random_phase(32'h0, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
